// File: rtl/prime_neighbour_pkg.sv
// Shared types and helpers for the prime neighbour engine: FSM state encoding
// and a digit-count-generic BCD incrementer.
package prime_neighbour_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    SEARCH = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int BCD_W          = 4;
  localparam int BCD_MAX_DIGITS = 8;
  localparam int BCD_MAX_W      = BCD_W * BCD_MAX_DIGITS;

  // Increments the lowest 'digits' BCD digits of v; all-9s wraps to all-0s.
  function automatic logic [BCD_MAX_W-1:0] bcd_inc(input logic [BCD_MAX_W-1:0] v,
                                                   input int digits);
    logic [BCD_MAX_W-1:0] r;
    logic                 carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      if (carry && (i < digits)) begin
        if (r[i*BCD_W +: BCD_W] == 4'd9) begin
          r[i*BCD_W +: BCD_W] = 4'd0;
          carry               = 1'b1;
        end else begin
          r[i*BCD_W +: BCD_W] = r[i*BCD_W +: BCD_W] + 4'd1;
          carry               = 1'b0;
        end
      end else begin
        carry = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/prime_neighbour_engine_trial_divider.sv
// Multi-cycle primality test by trial division: one divisor tried per cycle,
// stopping once d*d exceeds the candidate.
module trial_divider
  import prime_neighbour_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] c,
  output logic             done,
  output logic             is_prime
);

  logic [WIDTH-1:0]   c_r;
  logic [WIDTH-1:0]   d_r;
  logic               busy_r;
  logic               done_r;
  logic               prime_r;
  logic [2*WIDTH-1:0] dsq_s;
  logic [2*WIDTH-1:0] cext_s;

  assign dsq_s    = {{WIDTH{1'b0}}, d_r} * {{WIDTH{1'b0}}, d_r};
  assign cext_s   = {{WIDTH{1'b0}}, c_r};
  assign done     = done_r;
  assign is_prime = prime_r;

  // Divisor iteration; start always restarts, even on the cycle done pulses.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      c_r     <= {WIDTH{1'b0}};
      d_r     <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      prime_r <= 1'b0;
    end else if (clear) begin
      c_r     <= {WIDTH{1'b0}};
      d_r     <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      prime_r <= 1'b0;
    end else if (start) begin
      c_r    <= c;
      d_r    <= WIDTH'(2);
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      if (c_r < WIDTH'(2)) begin
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
        prime_r <= 1'b0;
      end else if (dsq_s > cext_s) begin
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
        prime_r <= 1'b1;
      end else if ((c_r % d_r) == {WIDTH{1'b0}}) begin
        busy_r  <= 1'b0;
        done_r  <= 1'b1;
        prime_r <= 1'b0;
      end else begin
        d_r <= d_r + WIDTH'(1);
      end
    end else begin
      done_r <= 1'b0;
    end
  end

endmodule

// File: rtl/prime_neighbour_engine.sv
// Number-class engine: checks prime / non-prime class of the operand, then
// returns its neighbour and BCD usage counts per class and direction.
module prime_neighbour_engine
  import prime_neighbour_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int CNT_DIGITS = 2
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          number,
  input  logic                      selection,
  input  logic                      mode,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          digit0,
  output logic [WIDTH-1:0]          digit1,
  output logic [BCD_W*CNT_DIGITS-1:0] count1,
  output logic [BCD_W*CNT_DIGITS-1:0] count0,
  output logic                      warning
);

  localparam int               CW    = BCD_W * CNT_DIGITS;
  localparam logic [WIDTH-1:0] MAX_N = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  state_t                  state_r, state_nx_s;
  logic [WIDTH-1:0]        n_r, cand_r;
  logic                    sel_r, mode_r;
  logic                    td_start_s, td_done_s, td_prime_s;
  logic [WIDTH-1:0]        td_c_s;
  logic                    load_s, cand_ld_s, fin_s, fin_ok_s, class_ok_s;
  logic [WIDTH-1:0]        cand_nx_s, fin_res_s, shift_s;
  logic [1:0][1:0][CW-1:0] cnt_r;
  logic [BCD_MAX_W-1:0]    inc_full_s;
  logic [CW-1:0]           inc_s;
  logic                    in_ready_r, out_valid_r, warning_r;
  logic [WIDTH-1:0]        digit0_r, digit1_r;
  logic [CW-1:0]           count1_r, count0_r;

  // Forward wraps past the top to 2; backward below 2 resumes from the top.
  function automatic logic [WIDTH-1:0] step_cand(input logic [WIDTH-1:0] v, input logic fwd);
    logic [WIDTH-1:0] r;
    if (fwd) begin
      if (v == MAX_N) r = TWO;
      else            r = v + ONE;
    end else begin
      if (v <= TWO) r = MAX_N;
      else          r = v - ONE;
    end
    return r;
  endfunction

  trial_divider #(.WIDTH(WIDTH)) u_td (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .clear    (clear),
    .start    (td_start_s),
    .c        (td_c_s),
    .done     (td_done_s),
    .is_prime (td_prime_s)
  );

  assign class_ok_s = sel_r ? ((n_r != {WIDTH{1'b0}}) && !td_prime_s) : td_prime_s;
  assign shift_s    = mode_r ? {n_r[WIDTH-2:0], 1'b0} : {1'b0, n_r[WIDTH-1:1]};
  assign inc_full_s = bcd_inc(BCD_MAX_W'(cnt_r[sel_r][mode_r]), CNT_DIGITS);
  assign inc_s      = inc_full_s[CW-1:0];

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign digit0    = digit0_r;
  assign digit1    = digit1_r;
  assign count1    = count1_r;
  assign count0    = count0_r;
  assign warning   = warning_r;

  // Next-state and datapath strobes.
  always_comb begin
    state_nx_s = state_r;
    td_start_s = 1'b0;
    td_c_s     = {WIDTH{1'b0}};
    load_s     = 1'b0;
    cand_ld_s  = 1'b0;
    cand_nx_s  = cand_r;
    fin_s      = 1'b0;
    fin_ok_s   = 1'b0;
    fin_res_s  = {WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          load_s     = 1'b1;
          td_start_s = 1'b1;
          td_c_s     = number;
          state_nx_s = CHECK;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CHECK: begin
        if (!td_done_s) begin
          state_nx_s = CHECK;
        end else if (!class_ok_s) begin
          fin_s      = 1'b1;
          state_nx_s = DONE;
        end else if (sel_r) begin
          fin_s      = 1'b1;
          fin_ok_s   = 1'b1;
          fin_res_s  = shift_s;
          state_nx_s = DONE;
        end else begin
          cand_nx_s  = step_cand(n_r, mode_r);
          cand_ld_s  = 1'b1;
          td_start_s = 1'b1;
          td_c_s     = cand_nx_s;
          state_nx_s = SEARCH;
        end
      end
      SEARCH: begin
        if (!td_done_s) begin
          state_nx_s = SEARCH;
        end else if (td_prime_s) begin
          fin_s      = 1'b1;
          fin_ok_s   = 1'b1;
          fin_res_s  = cand_r;
          state_nx_s = DONE;
        end else begin
          cand_nx_s  = step_cand(cand_r, mode_r);
          cand_ld_s  = 1'b1;
          td_start_s = 1'b1;
          td_c_s     = cand_nx_s;
          state_nx_s = SEARCH;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state, handshake flags, latched request and candidate.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      n_r         <= {WIDTH{1'b0}};
      sel_r       <= 1'b0;
      mode_r      <= 1'b0;
      cand_r      <= {WIDTH{1'b0}};
    end else if (clear) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      n_r         <= {WIDTH{1'b0}};
      sel_r       <= 1'b0;
      mode_r      <= 1'b0;
      cand_r      <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= fin_s;
      if (load_s) begin
        n_r    <= number;
        sel_r  <= selection;
        mode_r <= mode;
      end
      if (cand_ld_s) begin
        cand_r <= cand_nx_s;
      end
    end
  end

  // Result registers and usage counters, written as the engine enters DONE.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= '{default: {CW{1'b0}}};
      digit0_r  <= {WIDTH{1'b0}};
      digit1_r  <= {WIDTH{1'b0}};
      count1_r  <= {CW{1'b0}};
      count0_r  <= {CW{1'b0}};
      warning_r <= 1'b0;
    end else if (clear) begin
      cnt_r     <= '{default: {CW{1'b0}}};
      digit0_r  <= {WIDTH{1'b0}};
      digit1_r  <= {WIDTH{1'b0}};
      count1_r  <= {CW{1'b0}};
      count0_r  <= {CW{1'b0}};
      warning_r <= 1'b0;
    end else if (fin_s && fin_ok_s) begin
      digit0_r               <= n_r;
      digit1_r               <= fin_res_s;
      warning_r              <= 1'b0;
      cnt_r[sel_r][mode_r]   <= inc_s;
      count1_r               <= mode_r ? inc_s : cnt_r[sel_r][1];
      count0_r               <= mode_r ? cnt_r[sel_r][0] : inc_s;
    end else if (fin_s) begin
      warning_r <= 1'b1;
    end else begin
      warning_r <= warning_r;
    end
  end

endmodule
